// File: rtl/pad_ring_seq.sv
// Pad ring power-up / sleep isolation sequencer: holds pads safe until the I/O supply settles,
// then applies pad configuration, enables drivers and releases core reset. Optional macro: PAD_PLL_WAIT_EN.
module pad_ring_seq #(
  parameter int SETTLE_CYCLES   = 256,
  parameter int CORE_RST_CYCLES = 16,
  parameter int CNT_W           = 9,
  parameter int NGRP            = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pll_lock_i,
  input  logic [2*NGRP-1:0] cfg_ds_i,
  input  logic [NGRP-1:0]   cfg_pe_i,
  input  logic              sleep_req_i,
  output logic              pad_oe_o,
  output logic [2*NGRP-1:0] pad_ds_o,
  output logic [NGRP-1:0]   pad_pe_o,
  output logic              core_rst_o,
  output logic              sleep_ack_o,
  output logic              ready_o
);

  typedef enum logic [2:0] {
    ST_HOLD   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_CFG    = 3'd2,
    ST_CRST   = 3'd3,
    ST_RUN    = 3'd4,
    ST_ISO    = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0]  SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CRST_LOAD   = CNT_W'(CORE_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ZERO    = '0;
  localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);
  localparam logic [NGRP-1:0]   PE_SAFE     = '1;
  localparam logic [2*NGRP-1:0] DS_SAFE     = '0;

  state_t            state_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              warm_r;
  logic              lock_ok_s;

`ifdef PAD_PLL_WAIT_EN
  logic [1:0] lock_sync_r;

  // Two-flop synchronizer for the asynchronous PLL lock
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_sync_r <= 2'b00;
    end else begin
      lock_sync_r <= {lock_sync_r[0], pll_lock_i};
    end
  end

  assign lock_ok_s = lock_sync_r[1];
`else
  logic unused_lock_s;
  assign unused_lock_s = pll_lock_i;
  assign lock_ok_s     = 1'b1;
`endif

  // Sequencer state, down-counter, warm flag and all registered pad/core outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_HOLD;
      cnt_r       <= CNT_ZERO;
      warm_r      <= 1'b0;
      pad_oe_o    <= 1'b0;
      pad_ds_o    <= DS_SAFE;
      pad_pe_o    <= PE_SAFE;
      core_rst_o  <= 1'b1;
      sleep_ack_o <= 1'b0;
      ready_o     <= 1'b0;
    end else if (!lock_ok_s) begin
      // Lost (or not yet gained) lock: behave exactly as a fresh reset
      state_r     <= ST_HOLD;
      cnt_r       <= CNT_ZERO;
      warm_r      <= 1'b0;
      pad_oe_o    <= 1'b0;
      pad_ds_o    <= DS_SAFE;
      pad_pe_o    <= PE_SAFE;
      core_rst_o  <= 1'b1;
      sleep_ack_o <= 1'b0;
      ready_o     <= 1'b0;
    end else begin
      case (state_r)
        ST_HOLD: begin
          state_r <= ST_SETTLE;
          cnt_r   <= SETTLE_LOAD;
        end
        ST_SETTLE: begin
          pad_oe_o <= 1'b0;
          pad_pe_o <= PE_SAFE;
          if (cnt_r == CNT_ZERO) begin
            state_r <= ST_CFG;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        ST_CFG: begin
          pad_ds_o <= cfg_ds_i;
          pad_pe_o <= cfg_pe_i;
          pad_oe_o <= 1'b1;
          if (warm_r) begin
            state_r    <= ST_RUN;
            core_rst_o <= 1'b0;
            ready_o    <= 1'b1;
          end else begin
            state_r    <= ST_CRST;
            cnt_r      <= CRST_LOAD;
            core_rst_o <= 1'b1;
          end
        end
        ST_CRST: begin
          if (cnt_r == CNT_ZERO) begin
            state_r    <= ST_RUN;
            core_rst_o <= 1'b0;
            ready_o    <= 1'b1;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        ST_RUN: begin
          if (sleep_req_i) begin
            state_r     <= ST_ISO;
            pad_oe_o    <= 1'b0;
            pad_pe_o    <= PE_SAFE;
            sleep_ack_o <= 1'b1;
            ready_o     <= 1'b0;
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_ISO: begin
          // Wake skips core reset; configuration is re-latched on the way back
          if (!sleep_req_i) begin
            state_r     <= ST_SETTLE;
            cnt_r       <= SETTLE_LOAD;
            warm_r      <= 1'b1;
            sleep_ack_o <= 1'b0;
          end else begin
            state_r <= ST_ISO;
          end
        end
        default: begin
          state_r     <= ST_HOLD;
          cnt_r       <= CNT_ZERO;
          warm_r      <= 1'b0;
          pad_oe_o    <= 1'b0;
          pad_ds_o    <= DS_SAFE;
          pad_pe_o    <= PE_SAFE;
          core_rst_o  <= 1'b1;
          sleep_ack_o <= 1'b0;
          ready_o     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pad_ring_seq.sv
// Directed self-checking bench for pad_ring_seq (SETTLE_CYCLES=8, CORE_RST_CYCLES=4).
module tb_pad_ring_seq;

  logic       clk;
  logic       rst;
  logic       pll_lock_i;
  logic [7:0] cfg_ds_i;
  logic [3:0] cfg_pe_i;
  logic       sleep_req_i;
  logic       pad_oe_o;
  logic [7:0] pad_ds_o;
  logic [3:0] pad_pe_o;
  logic       core_rst_o;
  logic       sleep_ack_o;
  logic       ready_o;

  int n_checks = 0;
  int n_pass   = 0;

`ifdef PAD_PLL_WAIT_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  // {oe, ds, pe, core_rst, ack, ready}
  localparam logic [15:0] RST_OUTS = {1'b0, 8'h00, 4'hF, 1'b1, 1'b0, 1'b0};

  pad_ring_seq #(
    .SETTLE_CYCLES   (8),
    .CORE_RST_CYCLES (4),
    .CNT_W           (9),
    .NGRP            (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pll_lock_i  (pll_lock_i),
    .cfg_ds_i    (cfg_ds_i),
    .cfg_pe_i    (cfg_pe_i),
    .sleep_req_i (sleep_req_i),
    .pad_oe_o    (pad_oe_o),
    .pad_ds_o    (pad_ds_o),
    .pad_pe_o    (pad_pe_o),
    .core_rst_o  (core_rst_o),
    .sleep_ack_o (sleep_ack_o),
    .ready_o     (ready_o)
  );

  // Free-running 100 MHz clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] outs();
    return {pad_oe_o, pad_ds_o, pad_pe_o, core_rst_o, sleep_ack_o, ready_o};
  endfunction

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Cold sequence from rst release; edge k=0 is the first edge that can leave HOLD
  task automatic cold_run(input logic [7:0] ds_x, input logic [3:0] pe_x, input int last_k);
    for (int e = 0; e <= last_k + LAT; e++) begin
      int k;
      logic [15:0] exp;
      step(1);
      k = e - LAT;
      exp = {(k >= 9), (k >= 9) ? ds_x : 8'h00, (k >= 9) ? pe_x : 4'hF,
             (k < 13), 1'b0, (k >= 13)};
      check_value($sformatf("cold_k%0d", k), {16'h0000, outs()}, {16'h0000, exp});
    end
  endtask

  initial begin
    rst         = 1'b1;
    pll_lock_i  = 1'b1;
    sleep_req_i = 1'b0;
    cfg_ds_i    = 8'hA5;
    cfg_pe_i    = 4'h3;
    step(3);
    check_value("reset_state", {16'h0000, outs()}, {16'h0000, RST_OUTS});
    rst = 1'b0;
    cold_run(8'hA5, 4'h3, 15);

    // Configuration changes in RUN must not reach the pads
    cfg_ds_i = 8'h00;
    cfg_pe_i = 4'h0;
    step(3);
    check_value("cfg_held", {20'h00000, pad_ds_o, pad_pe_o}, {20'h00000, 8'hA5, 4'h3});
    check_value("run_ready", {31'h0, ready_o}, {31'h0, 1'b1});

    // Sleep round trip
    sleep_req_i = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step(1);
      check_value($sformatf("iso_%0d", i), {16'h0000, outs()},
                  {16'h0000, 1'b0, 8'hA5, 4'hF, 1'b0, 1'b1, 1'b0});
    end
    cfg_ds_i    = 8'h3C;
    cfg_pe_i    = 4'h9;
    sleep_req_i = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step(1);
      check_value($sformatf("wake_k%0d", k),
                  {17'h00000, pad_oe_o, pad_ds_o, pad_pe_o, core_rst_o, ready_o},
                  {17'h00000, (k >= 10), (k >= 10) ? 8'h3C : 8'hA5,
                   (k >= 10) ? 4'h9 : 4'hF, 1'b0, (k >= 10)});
    end

    // Reset asserted mid-count in CRST, then a full cold sequence
    rst = 1'b1;
    #1;
    check_value("rst_from_run", {16'h0000, outs()}, {16'h0000, RST_OUTS});
    step(1);
    rst = 1'b0;
    cold_run(8'h3C, 4'h9, 10);
    rst = 1'b1;
    #1;
    check_value("rst_async_crst", {16'h0000, outs()}, {16'h0000, RST_OUTS});
    step(1);
    rst = 1'b0;
    cold_run(8'h3C, 4'h9, 15);

`ifdef PAD_PLL_WAIT_EN
    // No lock: stay in HOLD; lock sampled at edge 20 leaves HOLD at edge 22
    rst        = 1'b1;
    pll_lock_i = 1'b0;
    step(1);
    rst = 1'b0;
    for (int e = 0; e < 20; e++) begin
      step(1);
      check_value($sformatf("nolock_e%0d", e), {16'h0000, outs()}, {16'h0000, RST_OUTS});
    end
    pll_lock_i = 1'b1;
    step(11);
    check_value("lock_oe_e30", {31'h0, pad_oe_o}, {31'h0, 1'b0});
    step(1);
    check_value("lock_oe_e31", {31'h0, pad_oe_o}, {31'h0, 1'b1});
    step(5);
    check_value("lock_run", {30'h0, ready_o, core_rst_o}, {30'h0, 1'b1, 1'b0});
    pll_lock_i = 1'b0;
    step(3);
    check_value("lock_lost", {30'h0, core_rst_o, pad_oe_o}, {30'h0, 1'b1, 1'b0});
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pad_ring_seq.md
# pad_ring_seq

Power-up and isolation sequencer for the chip pad ring. It holds all signal pads tristated with pulls enabled and the core in reset until the I/O supply has settled. It then applies the pad drive/pull configuration, enables the pad output drivers, and releases core reset. It sits at the top level between the reset pad and the core, and also handles sleep entry and exit by isolating the pads without resetting the core.

## Interface
Parameters:
- SETTLE_CYCLES, 256: pad supply settle time in clk cycles; legal range ≥1.
- CORE_RST_CYCLES, 16: cycles core reset stays high after pad outputs are enabled; legal range ≥1.
- CNT_W, 9: down-counter width; must hold max(SETTLE_CYCLES, CORE_RST_CYCLES)−1.
- NGRP, 4: number of pad groups, each with its own drive and pull controls.

Ports:
- clk  in  1  system clock from the clock pad.
- rst  in  1  reset from the reset pad. One clock; rst is asynchronous and active-high.
- pll_lock_i  in  1  PLL lock, asynchronous; used only with PAD_PLL_WAIT_EN.
- cfg_ds_i  in  2*NGRP  drive strength per group, quasi-static.
- cfg_pe_i  in  NGRP  pull enable per group, quasi-static.
- sleep_req_i  in  1  level request from the core to isolate the pads.
- pad_oe_o  out  1  global output enable for bidirectional and output pads.
- pad_ds_o  out  2*NGRP  registered drive strength to the pads.
- pad_pe_o  out  NGRP  registered pull enables to the pads.
- core_rst_o  out  1  core reset, active-high.
- sleep_ack_o  out  1  high while the pads are isolated at the core's request.
- ready_o  out  1  high in RUN.

## Operation
- All outputs are registered.
- Reset values:
  - pad_oe_o=0, pad_ds_o=0, pad_pe_o=all 1, core_rst_o=1, sleep_ack_o=0, ready_o=0.
  - State=HOLD, counter=0, warm flag=0.
- There is one CNT_W-bit down-counter, loaded on state entry.
- HOLD: outputs are at their reset values. Exit to SETTLE, loading the counter with SETTLE_CYCLES−1 (lock condition: see Configuration).
- SETTLE: pad_oe_o=0 and pads use the safe pulls.
  - Counter decrements once per cycle.
  - At 0, go to CFG.
- CFG: lasts one cycle.
  - Latch cfg_ds_i→pad_ds_o and cfg_pe_i→pad_pe_o.
  - If warm=0, go to CRST and load the counter with CORE_RST_CYCLES−1.
  - If warm=1, go directly to RUN.
- CRST: pad_oe_o=1 and core_rst_o=1. Counter decrements; at 0, go to RUN.
- RUN: pad_oe_o=1, core_rst_o=0, ready_o=1. If sleep_req_i=1, go to ISO.
- ISO: pad_oe_o=0, pad_pe_o=all 1, pad_ds_o is held, sleep_ack_o=1, core_rst_o stays 0.
  - When sleep_req_i=0, set warm=1 and go to SETTLE; configuration is then re-latched in CFG.
- The warm flag is cleared only by rst or on entry to HOLD.
- sleep_req_i is ignored in every state except RUN and ISO.
- Asserting rst in any state forces all reset values immediately (asynchronous). A count in progress is discarded.
- cfg_* changes while in RUN have no effect until the next CFG state.

## Timing
- Cold start without PAD_PLL_WAIT_EN: let edge 0 be the first rising clk edge with rst low.
  - State is SETTLE after edge 0.
  - CFG occupies edge SETTLE_CYCLES.
  - core_rst_o falls after edge SETTLE_CYCLES+CORE_RST_CYCLES+1.
  - pad_oe_o rises CORE_RST_CYCLES cycles before core_rst_o falls.
- Sleep entry: sleep_ack_o and pad_oe_o=0 take effect at the edge after sleep_req_i is sampled high in RUN.
- Wake: ready_o returns SETTLE_CYCLES+2 edges after sleep_req_i is sampled low in ISO.
- Simultaneous events: in the cycle the counter reaches 0, the transition wins. There is no extra wait cycle.

## Configuration
- PAD_PLL_WAIT_EN defined:
  - pll_lock_i passes through a 2-flop synchronizer, reset to 0.
  - HOLD exits only when the synchronized lock is 1. A lock sampled high at edge e leaves HOLD at edge e+2.
  - In any state other than HOLD, a synchronized lock of 0 returns to HOLD at the next edge. That edge forces reset output values and clears warm.
- PAD_PLL_WAIT_EN undefined:
  - pll_lock_i is unused and there is no synchronizer.
  - HOLD always exits at the first edge after rst is released.

## Test plan
- Cold start, macro off, SETTLE_CYCLES=8, CORE_RST_CYCLES=4: release rst -> pad_oe_o rises after edge 9, core_rst_o falls after edge 13, and ready_o=1 from then on.
- Config latch: cfg_ds_i=8'hA5 and cfg_pe_i=4'h3 during SETTLE, then changed to 8'h00 in RUN -> pad_ds_o=8'hA5 and pad_pe_o=4'h3 stay held.
- Sleep round-trip: sleep_req_i high for 5 cycles in RUN -> sleep_ack_o=1, pad_oe_o=0, pad_pe_o=4'hF, core_rst_o stays 0; after release, ready_o=1 10 edges later with core_rst_o never asserted.
- Reset mid-count: assert rst during CRST with counter=2 -> outputs take reset values without waiting for a clock edge; re-release -> full 14-edge cold sequence.
- Macro on: hold pll_lock_i=0 for 20 cycles -> remains in HOLD. Raise lock at edge 20 -> leaves HOLD at edge 22. Drop lock in RUN -> core_rst_o=1 and pad_oe_o=0 within 3 edges.
